kf_mac_arbiter: RTL
===================

# kf_mac_arbiter

Shares one matrix multiply-accumulate (MAC) datapath among the Kalman-filter stage engines (state prediction, gain calculation, state/covariance update). Each engine requests the MAC for a burst of operand beats. The arbiter grants one requester at a time, steers that requester's operand stream to the MAC, and holds the grant until the MAC reports that the burst's result is complete. It sits between the stage engines and the shared MAC, beneath the top-level Kalman control FSM.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- LEN_W, 8, width of per-requester burst-length field
- DATA_W, 64, operand beat width
- SRC_W, 2, width of source index; must be ≥ clog2(NREQ)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- req  in  NREQ  per-requester burst request, level
- req_len  in  NREQ*LEN_W  burst length L; burst is L+1 beats; slice i = [i*LEN_W +: LEN_W]
- req_valid  in  NREQ  operand beat valid
- req_data  in  NREQ*DATA_W  operand beat data
- req_ready  out  NREQ  operand beat accepted
- gnt  out  NREQ  one-hot grant
- done  out  NREQ  one-cycle burst-complete pulse
- mac_valid  out  1  beat valid to MAC
- mac_data  out  DATA_W  beat data to MAC
- mac_last  out  1  final beat of burst
- mac_src  out  SRC_W  index of granted requester
- mac_ready  in  1  MAC accepts beat
- mac_done  in  1  MAC result for current burst complete
- busy  out  1  arbiter not in S_IDLE

## Operation
The arbiter is a three-state FSM: S_IDLE, S_BURST, S_WAIT.

- **S_IDLE**
  - gnt = 0.
  - If any req bit is high, select a winner.
    - Round-robin: search upward from ptr with wrap.
    - ptr is the index after the last completed grant.
  - Register gnt to the winner's one-hot and mac_src to its index.
  - Load beat counter cnt with req_len[winner].
  - Go to S_BURST.
- **S_BURST**
  - Steering:
    - mac_valid = req_valid[g]
    - mac_data = req_data[g]
    - req_ready[g] = mac_ready
    - All other req_ready bits are 0.
  - A beat transfers when mac_valid && mac_ready.
  - mac_last = (cnt == 0) while in S_BURST.
  - On each transfer, cnt decrements.
  - On the transfer with cnt == 0, go to S_WAIT.
- **S_WAIT**
  - mac_valid = 0.
  - All req_ready bits are 0.
  - gnt is held.
  - On mac_done:
    - done[g] pulses for one cycle.
    - gnt clears.
    - ptr = (g+1) mod NREQ.
    - Go to S_IDLE.
- **Request handling**
  - req is sampled only in S_IDLE.
  - Deasserting req after grant has no effect; the burst runs to completion.
  - A requester deasserting req before it is granted is never granted.
- **mac_done outside S_WAIT** is ignored. The MAC must assert it no earlier than the cycle after the last beat.
- **req_len** is sampled once, at grant. Changes during the burst are ignored.
- **L wraps nothing**: L = 2^LEN_W − 1 gives 2^LEN_W beats.
- **mac_src** holds the last granted index while in S_IDLE. mac_data is don't-care when mac_valid = 0.

Reset values:
- state = S_IDLE, ptr = 0, cnt = 0
- gnt, done, req_ready, mac_valid, mac_last, busy = 0
- mac_src = 0

## Timing
- req rises in cycle t (FSM in S_IDLE) → gnt and busy high at t+1. The first beat can transfer at t+1.
- Burst of L+1 beats with no stalls → last beat at t+1+L. S_WAIT begins at t+2+L.
- mac_done high in cycle w (in S_WAIT) → done[g] high and gnt low at w+1, FSM in S_IDLE at w+1.
  - Next grant earliest at w+2. Minimum turnaround is one idle cycle.
- done is registered; mac_valid, mac_data, mac_last and req_ready are combinational from state, gnt, cnt and inputs.
- busy = (state != S_IDLE), registered with state.
- Reset asserted mid-burst: all outputs take reset values asynchronously; the partial burst is discarded and no done is issued.

## Configuration
- KF_ARB_FIXED_PRIO_EN **undefined**: round-robin arbitration starting at ptr, as described.
- KF_ARB_FIXED_PRIO_EN **defined**:
  - Fixed priority; lowest index wins.
  - ptr is not implemented.
  - All other behaviour is identical.

## Test plan
- **Single request**: req[1]=1, L=3, req_valid always 1, mac_ready always 1.
  - gnt=4'b0010 one cycle later; 4 beats; mac_last on the 4th only; mac_src=1.
  - mac_done two cycles later → done[1] single pulse; busy drops the same cycle.
- **Round-robin**: all four req held high, L=0, mac_done one cycle after each last beat.
  - Grant order 0,1,2,3,0,1.
  - With KF_ARB_FIXED_PRIO_EN defined, order is 0,0,0.
- **Backpressure**: L=2, mac_ready toggling 1,0,0,1,1,0,1.
  - Exactly 3 transfers.
  - req_ready[g] mirrors mac_ready; other req_ready bits stay 0.
  - mac_last asserted only while cnt==0.
- **Gaps and spurious done**: req_valid gaps mid-burst plus mac_done pulsed during S_BURST.
  - The mac_done pulse is ignored; the burst completes.
  - done fires only after mac_done in S_WAIT.
- **Late changes**: req dropped and req_len changed after grant.
  - Burst still runs the originally sampled L+1 beats; done is issued.
- **Reset mid-burst**: rst_n asserted after beat 2 of 5.
  - gnt=0, busy=0, no done.
  - After release, the next request from index 3 is granted first (ptr=0 search order from 0; only req[3] high).

Source files
------------

// File: rtl/kf_mac_arbiter_if.sv
// Bundle between the Kalman stage engines, the shared MAC and kf_mac_arbiter.
// The slave modport is the arbiter; the master modport is the engine/MAC side.
interface kf_mac_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 64,
    parameter int SRC_W  = 2
);
    logic [NREQ-1:0]        req;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic                   mac_valid;
    logic [DATA_W-1:0]      mac_data;
    logic                   mac_last;
    logic [SRC_W-1:0]       mac_src;
    logic                   mac_ready;
    logic                   mac_done;
    logic                   busy;

    modport master (
        output req, req_len, req_valid, req_data, mac_ready, mac_done,
        input  req_ready, gnt, done, mac_valid, mac_data, mac_last, mac_src, busy
    );

    modport slave (
        input  req, req_len, req_valid, req_data, mac_ready, mac_done,
        output req_ready, gnt, done, mac_valid, mac_data, mac_last, mac_src, busy
    );
endinterface

// File: rtl/kf_mac_arbiter.sv
// Grants the shared MAC to one stage engine per burst and steers its operand stream.
// Define KF_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module kf_mac_arbiter #(
    parameter int NREQ   = 4,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 64,
    parameter int SRC_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    kf_mac_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BURST = 2'd1, S_WAIT = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [NREQ-1:0]   gnt_q, done_q, rdy_c;
    logic [SRC_W-1:0]  src_q, win_idx;
    logic [LEN_W-1:0]  cnt;
    logic              win_found, busy_q, vld_c, last_c, xfer;
    logic [DATA_W-1:0] data_c;
`ifndef KF_ARB_FIXED_PRIO_EN
    logic [SRC_W-1:0]  ptr;
`endif

    // First requester found scanning upward from the search origin with wrap.
    always_comb begin
        int j;
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef KF_ARB_FIXED_PRIO_EN
            j = k;
`else
            j = (int'(ptr) + k) % NREQ;
`endif
            if (!win_found && bus.req[j]) begin
                win_found = 1'b1;
                win_idx   = SRC_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        vld_c     = 1'b0;
        last_c    = 1'b0;
        rdy_c     = '0;
        data_c    = bus.req_data[src_q*DATA_W +: DATA_W];
        if (state == S_BURST) begin
            vld_c  = bus.req_valid[src_q];
            last_c = (cnt == '0);
            rdy_c  = bus.mac_ready ? gnt_q : '0;
        end
        xfer = vld_c & bus.mac_ready;
        case (state)
            S_IDLE:  if (win_found)             state_nxt = S_BURST;
            S_BURST: if (xfer && cnt == '0)     state_nxt = S_WAIT;
            S_WAIT:  if (bus.mac_done)          state_nxt = S_IDLE;
            default:                            state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= '0;
            src_q  <= '0;
            cnt    <= '0;
            done_q <= '0;
            busy_q <= 1'b0;
`ifndef KF_ARB_FIXED_PRIO_EN
            ptr    <= '0;
`endif
        end else begin
            done_q <= '0;
            busy_q <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: if (win_found) begin
                    gnt_q <= NREQ'(1) << win_idx;
                    src_q <= win_idx;
                    cnt   <= bus.req_len[win_idx*LEN_W +: LEN_W];
                end
                // cnt parks at zero after the last beat so mac_last stays meaningful.
                S_BURST: if (xfer && cnt != '0) cnt <= cnt - 1'b1;
                S_WAIT: if (bus.mac_done) begin
                    done_q <= gnt_q;
                    gnt_q  <= '0;
`ifndef KF_ARB_FIXED_PRIO_EN
                    ptr    <= (src_q == SRC_W'(NREQ-1)) ? '0 : src_q + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.mac_src   = src_q;
    assign bus.mac_valid = vld_c;
    assign bus.mac_data  = data_c;
    assign bus.mac_last  = last_c;
    assign bus.req_ready = rdy_c;
endmodule
